// File: rtl/multdiv_seq_pkg.sv
// Shared constants, state/adder-op encodings and the counter helper for the
// iterative multiply/divide unit.
package multdiv_seq_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 6;

    localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MULT_IT,
        DIV_ABS_A,
        DIV_ABS_B,
        DIV_IT,
        DIV_FIX,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        NEG,
        NONE
    } add_op_t;

    // Half-adder ripple increment so the only arithmetic adder stays the CLA.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < CNT_W; i++) begin
            cnt_inc[i] = c[i] ^ carry;
            carry      = carry & c[i];
        end
    endfunction

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained through
// group generate/propagate terms.
module cla_32 (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [7:0]  gg;
    logic [7:0]  pg;
    logic [8:0]  cg;

    assign g = in1 & in2;
    assign p = in1 ^ in2;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_grp
            logic [3:0] gl;
            logic [3:0] pl;
            logic [3:0] c;
            assign gl   = g[gi*4 +: 4];
            assign pl   = p[gi*4 +: 4];
            assign c[0] = cg[gi];
            assign c[1] = gl[0] | (pl[0] & cg[gi]);
            assign c[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & cg[gi]);
            assign c[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                        | (pl[2] & pl[1] & pl[0] & cg[gi]);
            assign gg[gi] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                          | (pl[3] & pl[2] & pl[1] & gl[0]);
            assign pg[gi] = &pl;
            assign sum[gi*4 +: 4] = pl ^ c;
        end
    endgenerate

    always_comb begin
        cg[0] = cin;
        for (int i = 0; i < 8; i++) begin
            cg[i+1] = gg[i] | (pg[i] & cg[i]);
        end
    end

    assign cout = cg[8];

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed 32-bit multiply (radix-2 Booth) / divide (restoring on
// magnitudes) sharing a single cla_32 for every add, subtract and negate.
module multdiv_seq
    import multdiv_seq_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t state_reg, state_next;

    // p_hi doubles as the remainder and p_lo as the quotient during divide.
    logic [WIDTH-1:0] p_hi_reg, p_lo_reg, m_reg;
    logic             q_1_reg, mult_reg, neg_q_reg, div_exc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             exc_reg, rdy_reg;

    add_op_t          add_op;
    logic [WIDTH-1:0] add_in1, neg_src;
    logic [WIDTH-1:0] cla_a, cla_b, cla_sum;
    logic             cla_cin, cla_cout;
    logic [WIDTH-1:0] r_shift, booth_hi;
    logic             div_special;

    assign r_shift     = {p_hi_reg[WIDTH-2:0], p_lo_reg[WIDTH-1]};
    assign div_special = (data_operandB == '0)
                       || ((data_operandA == INT_MIN) && (data_operandB == NEG_ONE));
    assign booth_hi    = ((add_op == ADD) || (add_op == SUB)) ? cla_sum : p_hi_reg;

    always_comb begin
        state_next = state_reg;
        add_op     = NONE;
        add_in1    = p_hi_reg;
        neg_src    = m_reg;
        case (state_reg)
            MULT_IT: begin
                if ({p_lo_reg[0], q_1_reg} == 2'b01) add_op = ADD;
                if ({p_lo_reg[0], q_1_reg} == 2'b10) add_op = SUB;
                if (cnt_reg == LAST_ITER) state_next = DONE;
            end
            DIV_ABS_A: begin
                if (p_lo_reg[WIDTH-1]) add_op = NEG;
                neg_src    = p_lo_reg;
                state_next = DIV_ABS_B;
            end
            DIV_ABS_B: begin
                if (m_reg[WIDTH-1]) add_op = NEG;
                neg_src    = m_reg;
                state_next = DIV_IT;
            end
            DIV_IT: begin
                add_op  = SUB;
                add_in1 = r_shift;
                if (cnt_reg == LAST_ITER) state_next = DIV_FIX;
            end
            DIV_FIX: begin
                if (neg_q_reg) add_op = NEG;
                neg_src    = p_lo_reg;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A new start always preempts whatever is in flight.
        if (ctrl_MULT) begin
            state_next = MULT_IT;
        end else if (ctrl_DIV) begin
            state_next = div_special ? DONE : DIV_ABS_A;
        end
    end

    always_comb begin
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        case (add_op)
            ADD: begin
                cla_a = add_in1;
                cla_b = m_reg;
            end
            SUB: begin
                cla_a   = add_in1;
                cla_b   = ~m_reg;
                cla_cin = 1'b1;
            end
            NEG: begin
                cla_b   = ~neg_src;
                cla_cin = 1'b1;
            end
            default: ;
        endcase
    end

    cla_32 u_cla (
        .in1  (cla_a),
        .in2  (cla_b),
        .cin  (cla_cin),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            p_hi_reg    <= '0;
            p_lo_reg    <= '0;
            m_reg       <= '0;
            q_1_reg     <= 1'b0;
            mult_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            div_exc_reg <= 1'b0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            exc_reg     <= 1'b0;
            rdy_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            rdy_reg   <= 1'b0;
            if (ctrl_MULT) begin
                p_hi_reg    <= '0;
                p_lo_reg    <= data_operandA;
                q_1_reg     <= 1'b0;
                m_reg       <= data_operandB;
                cnt_reg     <= '0;
                mult_reg    <= 1'b1;
                div_exc_reg <= 1'b0;
            end else if (ctrl_DIV) begin
                p_hi_reg    <= '0;
                q_1_reg     <= 1'b0;
                m_reg       <= data_operandB;
                cnt_reg     <= '0;
                mult_reg    <= 1'b0;
                neg_q_reg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                div_exc_reg <= div_special;
                if (data_operandB == '0) p_lo_reg <= '0;
                else                     p_lo_reg <= data_operandA;
            end else begin
                case (state_reg)
                    MULT_IT: begin
                        p_hi_reg <= {booth_hi[WIDTH-1], booth_hi[WIDTH-1:1]};
                        p_lo_reg <= {booth_hi[0], p_lo_reg[WIDTH-1:1]};
                        q_1_reg  <= p_lo_reg[0];
                        cnt_reg  <= cnt_inc(cnt_reg);
                    end
                    DIV_ABS_A: if (p_lo_reg[WIDTH-1]) p_lo_reg <= cla_sum;
                    DIV_ABS_B: if (m_reg[WIDTH-1]) m_reg <= cla_sum;
                    DIV_IT: begin
                        p_hi_reg <= cla_cout ? cla_sum : r_shift;
                        p_lo_reg <= {p_lo_reg[WIDTH-2:0], cla_cout};
                        cnt_reg  <= cnt_inc(cnt_reg);
                    end
                    DIV_FIX: if (neg_q_reg) p_lo_reg <= cla_sum;
                    DONE: begin
                        result_reg <= p_lo_reg;
                        exc_reg    <= mult_reg ? (p_hi_reg != {WIDTH{p_lo_reg[WIDTH-1]}})
                                               : div_exc_reg;
                        rdy_reg    <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomized and directed bench for multdiv_seq against a latency/arithmetic
// reference model checked on every cycle.
module tb_multdiv_seq;
    import multdiv_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    always #5 clock = ~clock;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    // Reference: exact arithmetic plus a countdown to the RDY cycle.
    bit          m_pending;
    int          m_left;
    logic [31:0] m_pres, m_res;
    logic        m_pexc, m_exc, m_rdy;

    function automatic void ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e, output int lat);
        longint prod;
        if (mul) begin
            prod = longint'($signed(a)) * longint'($signed(b));
            r    = prod[31:0];
            e    = (prod[63:32] != {32{prod[31]}});
            lat  = 33;
        end else if (b == 32'd0) begin
            r = 32'd0; e = 1'b1; lat = 1;
        end else if (a == INT_MIN && b == NEG_ONE) begin
            r = INT_MIN; e = 1'b1; lat = 1;
        end else begin
            r = $signed(a) / $signed(b);
            e = 1'b0; lat = 36;
        end
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_pending = 1'b0; m_res = '0; m_exc = 1'b0; m_rdy = 1'b0;
        end else begin
            m_rdy = 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                ref_op(ctrl_MULT, data_operandA, data_operandB, m_pres, m_pexc, m_left);
                m_pending = 1'b1;
            end else if (m_pending) begin
                m_left--;
                if (m_left == 0) begin
                    m_pending = 1'b0;
                    m_rdy     = 1'b1;
                    m_res     = m_pres;
                    m_exc     = m_pexc;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (checking) begin
            vectors++;
            if (data_resultRDY !== m_rdy || data_result !== m_res || data_exception !== m_exc) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t: got rdy=%b res=%h exc=%b, expected rdy=%b res=%h exc=%b",
                         $time, data_resultRDY, data_result, data_exception, m_rdy, m_res, m_exc);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic start_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = mul; ctrl_DIV = dv; data_operandA = a; data_operandB = b;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        while (data_resultRDY !== 1'b1 && lat < 60) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic directed(input string name, input bit mul, input bit dv,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic ee, input int elat);
        int lat;
        start_op(mul, dv, a, b);
        wait_rdy(lat);
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " result"}, data_result, er);
        check({name, " exception"}, {31'd0, data_exception}, {31'd0, ee});
        @(negedge clock);
        check({name, " rdy_one_cycle"}, {31'd0, data_resultRDY}, 32'd0);
        $display("op %s: A=%h B=%h -> %h exc=%b lat=%0d", name, a, b, data_result, data_exception, lat);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'($urandom_range(0, 20));
            1: v = -32'($urandom_range(1, 20));
            2: v = INT_MIN;
            3: v = NEG_ONE;
            4: v = 32'd0;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int lat, rdy_seen, n;
        bit mul;
        logic [31:0] a, b;

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        checking = 1'b1;
        check("reset result", data_result, 32'd0);
        check("reset exception", {31'd0, data_exception}, 32'd0);
        check("reset rdy", {31'd0, data_resultRDY}, 32'd0);

        directed("mul_7x-3", 1, 0, 32'd7, -32'd3, 32'hFFFF_FFEB, 1'b0, 33);
        directed("mul_ovf", 1, 0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 33);
        directed("mul_min_x1", 1, 0, INT_MIN, 32'd1, 32'h8000_0000, 1'b0, 33);
        directed("div_-7/2", 0, 1, -32'd7, 32'd2, 32'hFFFF_FFFD, 1'b0, 36);
        directed("div_100/7", 0, 1, 32'd100, 32'd7, 32'd14, 1'b0, 36);
        directed("div_by_zero", 0, 1, 32'd5, 32'd0, 32'd0, 1'b1, 1);
        directed("div_min/-1", 0, 1, INT_MIN, NEG_ONE, 32'h8000_0000, 1'b1, 1);
        directed("both_6x4", 1, 1, 32'd6, 32'd4, 32'd24, 1'b0, 33);

        // Restart: DIV issued at edge 10 of a MULT.
        start_op(1, 0, 32'd123, 32'd456);
        repeat (8) @(negedge clock);
        directed("restart_div_9/3", 0, 1, 32'd9, 32'd3, 32'd3, 1'b0, 36);

        // Reset at edge 20 of a MULT.
        start_op(1, 0, 32'd77, 32'd99);
        repeat (19) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("midreset result", data_result, 32'd0);
        check("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        rdy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check("midreset no_rdy", 32'(rdy_seen), 32'd0);
        $display("op midreset: rdy pulses after reset=%0d", rdy_seen);

        directed("after_reset_mul", 1, 0, -32'd12, -32'd12, 32'd144, 1'b0, 33);
        directed("after_reset_div", 0, 1, 32'd1000, -32'd33, -32'd30, 1'b0, 36);

        for (int i = 0; i < 150; i++) begin
            mul = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            if (mul && b == INT_MIN) b = 32'h8000_0001;
            start_op(mul, !mul, a, b);
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, 30);
                repeat (n) @(negedge clock);
                $display("op rand%0d: %s A=%h B=%h aborted after %0d cycles", i, mul ? "MUL" : "DIV", a, b, n);
            end else begin
                n = 0;
                while (m_pending && n < 60) begin
                    @(negedge clock);
                    n++;
                end
                check("rand wait_bound", {31'd0, m_pending}, 32'd0);
                $display("op rand%0d: %s A=%h B=%h -> %h exc=%b", i, mul ? "MUL" : "DIV", a, b, data_result, data_exception);
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
        end

        repeat (40) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
- Iterative signed 32-bit multiply/divide unit for the simple ALU.
- Time-shares one cla_32 instance as its only adder. Multiply uses radix-2 Booth; divide uses restoring division on magnitudes.
- A FSM sequences operand latch, add/subtract, shift and sign fix-up.
- Sits beside the single-cycle ALU; the core stalls on it until data_resultRDY.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported because it is tied to cla_32.
- ITERS, 32, iteration count. Must equal WIDTH.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- ctrl_MULT  in  1  one-cycle start pulse: multiply.
- ctrl_DIV  in  1  one-cycle start pulse: divide.
- data_operandA  in  32  multiplicand / dividend (signed); sampled only on the start edge.
- data_operandB  in  32  multiplier / divisor (signed); sampled only on the start edge.
- data_result  out  32  product low word / quotient.
- data_exception  out  1  multiply overflow, divide-by-zero, or -2^31/-1.
- data_resultRDY  out  1  one-cycle pulse: result and exception valid.

Behaviour:
- Reset:
  - State goes to IDLE.
  - data_result=0, data_exception=0, data_resultRDY=0.
  - Internal registers cleared.
  - Reset mid-operation abandons the operation; no RDY pulse follows.
- States: IDLE, MULT_IT, DIV_ABS_A, DIV_ABS_B, DIV_IT, DIV_FIX, DONE.
- Start:
  - A start pulse in any state, including mid-operation, aborts the current operation, latches the operands and begins a new one.
  - ctrl_MULT and ctrl_DIV both high: multiply wins, divide is ignored.
- Adder sharing:
  - Exactly one cla_32 instance.
  - Add: in2=M, cin=0. Subtract/negate: in2=~M, cin=1.
  - The FSM drives the adder mux in every state. No other +/- operator in this block.
- Multiply (Booth):
  - Register {P_hi[31:0], P_lo[31:0], q_1}; start loads P_hi=0, P_lo=A, q_1=0, M=B.
  - MULT_IT, 32 cycles. Each cycle:
    - Inspect {P_lo[0], q_1}: 01 gives P_hi+M; 10 gives P_hi-M; 00 and 11 give no change.
    - Then arithmetic shift right of the 65-bit register.
  - Counter 0..31, then DONE.
  - Result = P_lo. exception = (P_hi != {32{P_lo[31]}}).
- Divide:
  - At the start edge:
    - B==0: go directly to DONE with result=0, exception=1.
    - A==32'h80000000 and B==32'hFFFFFFFF: DONE with result=32'h80000000, exception=1.
  - DIV_ABS_A: Q=|A| via adder negate if A[31]. DIV_ABS_B: D=|B|.
  - DIV_IT, 32 cycles, R starts 0:
    - {R,Q} shift left 1.
    - Trial T=R-D via adder.
    - If cout=1 (R>=D): R=T, Q[0]=1; else R unchanged, Q[0]=0.
    - Unsigned 32-bit R never overflows because |D|>=1 and R<D.
  - DIV_FIX: Q=-Q if A[31]^B[31]. Quotient truncates toward zero; remainder is not output.
- DONE:
  - One cycle; data_resultRDY=1, data_result and data_exception updated.
  - Next edge returns to IDLE.
  - Outputs hold until the next DONE or reset.
- Latency, counted in edges after the start edge until the RDY-high cycle:
  - Multiply: 33 (32 MULT_IT + DONE).
  - Divide: 36 (2 ABS + 32 DIV_IT + FIX + DONE).
  - Divide special cases: 1.
- No operand stability requirement after the start edge.
- data_resultRDY is never high for two consecutive cycles.

Decomposition:
- Shared package holds:
  - State encoding constants.
  - ITERS, and a 6-bit counter width.
  - Adder-op select codes: ADD, SUB, NEG, NONE.
  - Constants INT_MIN=32'h80000000, NEG_ONE=32'hFFFFFFFF.
- One natural sub-module: cla_32, instantiated once, unmodified.
- The datapath mux and FSM stay in multdiv_seq.

Test Plan:
- MULT: A=7, B=-3 -> data_result=32'hFFFFFFEB, exception=0, RDY exactly 33 edges after start, high one cycle.
- MULT: A=32'h00010000, B=32'h00010000 -> result=0, exception=1. Also A=-2^31, B=1 -> result=32'h80000000, exception=0.
- DIV: A=-7, B=2 -> result=32'hFFFFFFFD (-3), exception=0, RDY at edge 36. A=100, B=7 -> 14.
- DIV by zero (A=5, B=0) -> result=0, exception=1, RDY at edge 1. A=INT_MIN, B=-1 -> 32'h80000000, exception=1.
- Restart at edge 10 of a MULT with a new DIV 9/3 -> single RDY at 36 edges after the second start, result=3. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=4 -> 24.
- reset asserted at edge 20 of a MULT -> next cycle outputs 0, no RDY within 40 edges. Back-to-back operations after reset complete correctly.
